nco_sweep_ctrl: RTL and testbench
=================================

Name: nco_sweep_ctrl

Overview:
- Upstream control stage for the CORDIC sine/cosine NCO.
- Generates the per-cycle phase increment (Angle_o) and the NCO run control (Start_o) to perform programmable frequency sweeps: single up-ramp, continuous sawtooth, or continuous triangle.
- Angle_o drives NCO Angle_i; Start_o drives NCO Start_i. Start_o=0 runs the NCO; Start_o=1 holds the NCO idle with its accumulator cleared.

Parameters:
- W, 16, width of frequency words (FreqStart/Stop/Step, Angle_o); must match NCO Angle_i width.
- DWELL_W, 16, width of dwell counter and Dwell_i.
- IDX_W, 16, width of StepIdx_o.

Ports:
- Clk_i  in  1  single clock.
- Rst_i  in  1  synchronous, active-high reset.
- Go_i  in  1  start sweep; sampled only in IDLE.
- Abort_i  in  1  terminate sweep; honoured in any state.
- Mode_i  in  2  00 single up, 01 sawtooth, 10 triangle, 11 reserved (treated as 00).
- FreqStart_i  in  W  first increment.
- FreqStop_i  in  W  upper bound (inclusive).
- FreqStep_i  in  W  increment between points.
- Dwell_i  in  DWELL_W  cycles per point; 0 treated as 1.
- Angle_o  out  W  phase increment to NCO.
- Start_o  out  1  NCO run control, active low.
- Busy_o  out  1  sweep in progress.
- Done_o  out  1  one-cycle pulse at end of single sweep.
- Err_o  out  1  one-cycle pulse on rejected Go.
- StepIdx_o  out  IDX_W  points emitted since Go, mod 2^IDX_W.

Behaviour:
- Clock and reset: one clock, Clk_i. Reset is synchronous and active-high on Rst_i.
- Reset values: state=IDLE, Angle_o=0, Start_o=1, Busy_o=0, Done_o=0, Err_o=0, StepIdx_o=0.
- States:
  - IDLE: Start_o=1; Angle_o holds its last value.
  - UP.
  - DOWN.
- Go_i accepted in IDLE (cycle n):
  - Latches Mode, Start, Stop, Step and Dwell. Later input changes are ignored until the next Go.
  - If FreqStart_i > FreqStop_i: Err_o=1 at n+1, stay IDLE.
  - Otherwise at n+1: state=UP, Angle_o=FreqStart, Start_o=0, Busy_o=1, StepIdx_o=0.
- Go_i while in UP or DOWN: ignored.
- Dwell: each point is held for exactly max(Dwell,1) cycles. The down-counter reloads on every point change.
- Step arithmetic: next value computed in W+1 bits (no wrap). up_next = cur + Step; dn_next = cur - Step (signed W+1).
- UP at dwell expiry:
  - up_next <= Stop: Angle_o = up_next, StepIdx_o += 1.
  - Otherwise, by mode:
    - single: go to IDLE. Start_o=1, Busy_o=0 and Done_o=1 in the same cycle; Angle_o holds its last value.
    - sawtooth: Angle_o = Start, StepIdx_o += 1.
    - triangle:
      - If dn_next >= Start: state=DOWN, Angle_o = dn_next, StepIdx_o += 1.
      - Otherwise (Start==Stop or Step too large): Angle_o held, StepIdx_o += 1.
- DOWN at dwell expiry:
  - dn_next >= Start: Angle_o = dn_next.
  - Otherwise: state=UP, Angle_o = up_next (that is, cur + Step, no repeat of the endpoint).
  - StepIdx_o += 1 in both cases.
- Step == 0:
  - single: one point, then Done.
  - sawtooth and triangle: Angle_o = Start forever.
- Abort_i: from any state, at the next cycle state=IDLE, Start_o=1, Busy_o=0, no Done_o pulse. Abort_i and Go_i in the same cycle: Abort_i wins, no Err_o pulse.
- Rst_i mid-sweep: all registers return to reset values on the next edge.
- Latency: Go_i to first Angle_o/Start_o change is 1 cycle. Downstream NCO pipeline latency is not this block's concern.

Decomposition:
- Package nco_sweep_pkg holds:
  - MODE_SINGLE, MODE_SAW, MODE_TRI encodings;
  - state encoding IDLE/UP/DOWN;
  - default W.
- Natural sub-module: sweep_dwell_cnt. It is a loadable down-counter with a zero-as-one rule and a one-cycle expire pulse; the rest of the block is a single FSM plus datapath.

Test Plan:
- Single up, Start=100 Stop=400 Step=100 Dwell=3, Go at n -> Angle_o sequence:
  - 100 on n+1..n+3, 200 on n+4..n+6, 300 on n+7..n+9, 400 on n+10..n+12;
  - n+13: Start_o=1, Busy_o=0, Done_o=1 for one cycle; StepIdx_o=3.
- Non-multiple bound, Stop=350, same other settings -> last point 300, Done_o at n+10.
- Sawtooth, Start=0 Stop=200 Step=100 Dwell=1 -> 0,100,200,0,100,200,... with no Done_o. Abort at n+7 -> Start_o=1 at n+8, no Done_o pulse.
- Triangle, Start=0 Stop=300 Step=100 Dwell=1 -> 0,100,200,300,200,100,0,100,200,...
- Overflow edge, Start=FFF0 Stop=FFFF Step=0020 single -> one point FFF0, then Done_o (no wrap to 0010).
- Reject and collisions, each in IDLE:
  - Start=500 Stop=100 -> Err_o one cycle, Start_o stays 1.
  - Go+Abort in the same cycle -> nothing.
  - Dwell=0 -> points held 1 cycle.
  - Rst_i mid-sweep -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/nco_sweep_pkg.sv
// Shared encodings for the NCO frequency-sweep controller.
package nco_sweep_pkg;

  localparam int W_DEFAULT = 16;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_SAW    = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10
  } state_t;

  // Reserved mode 11 behaves as a single up-ramp.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_SINGLE : m;
  endfunction

endpackage

// File: rtl/sweep_dwell_cnt.sv
// Loadable dwell down-counter. A period of 0 behaves as 1. While running,
// expire is high during the last cycle of each point; the counter then
// reloads from the latched period so every point lasts exactly that long.
module sweep_dwell_cnt #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               load,
  input  logic [DWELL_W-1:0] period,
  input  logic               run,
  output logic               expire
);

  logic [DWELL_W-1:0] period_reg;
  logic [DWELL_W-1:0] cnt_reg;
  logic [DWELL_W-1:0] period_eff;

  assign period_eff = (period == '0) ? DWELL_W'(1) : period;
  assign expire     = run && (cnt_reg <= DWELL_W'(1));

  // Latch the period on load, count down while running, reload on expiry.
  always_ff @(posedge clk) begin
    if (srst) begin
      period_reg <= DWELL_W'(1);
      cnt_reg    <= DWELL_W'(1);
    end else if (load) begin
      period_reg <= period_eff;
      cnt_reg    <= period_eff;
    end else if (run) begin
      if (expire) cnt_reg <= period_reg;
      else        cnt_reg <= cnt_reg - DWELL_W'(1);
    end
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep controller feeding the CORDIC NCO: produces the phase
// increment and the active-low run control for single, sawtooth and
// triangle sweeps between latched start/stop bounds.
module nco_sweep_ctrl
  import nco_sweep_pkg::*;
#(
  parameter int W       = W_DEFAULT,
  parameter int DWELL_W = 16,
  parameter int IDX_W   = 16
) (
  input  logic               Clk_i,
  input  logic               Rst_i,
  input  logic               Go_i,
  input  logic               Abort_i,
  input  logic [1:0]         Mode_i,
  input  logic [W-1:0]       FreqStart_i,
  input  logic [W-1:0]       FreqStop_i,
  input  logic [W-1:0]       FreqStep_i,
  input  logic [DWELL_W-1:0] Dwell_i,
  output logic [W-1:0]       Angle_o,
  output logic               Start_o,
  output logic               Busy_o,
  output logic               Done_o,
  output logic               Err_o,
  output logic [IDX_W-1:0]   StepIdx_o
);

  state_t           state_reg, state_next;
  logic [1:0]       mode_reg, mode_next;
  logic [W-1:0]     fstart_reg, fstart_next;
  logic [W-1:0]     fstop_reg, fstop_next;
  logic [W-1:0]     fstep_reg, fstep_next;
  logic [W-1:0]     angle_reg, angle_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             start_reg, start_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;

  logic             dwell_load;
  logic             dwell_run;
  logic             dwell_expire;

  // Next-point candidates in W+1 bits so neither direction wraps.
  logic [W:0]       up_next;
  logic [W:0]       dn_next;
  logic             up_ok;
  logic             dn_ok;

  assign up_next = {1'b0, angle_reg} + {1'b0, fstep_reg};
  assign dn_next = {1'b0, angle_reg} - {1'b0, fstep_reg};
  // A zero step in single mode must still terminate after one point.
  assign up_ok   = (up_next <= {1'b0, fstop_reg}) &&
                   !((fstep_reg == '0) && (mode_reg == MODE_SINGLE));
  assign dn_ok   = !dn_next[W] && (dn_next[W-1:0] >= fstart_reg);

  assign dwell_run = (state_reg != ST_IDLE);

  sweep_dwell_cnt #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk    (Clk_i),
    .srst   (Rst_i),
    .load   (dwell_load),
    .period (Dwell_i),
    .run    (dwell_run),
    .expire (dwell_expire)
  );

  // State and datapath registers.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_reg  <= ST_IDLE;
      mode_reg   <= MODE_SINGLE;
      fstart_reg <= '0;
      fstop_reg  <= '0;
      fstep_reg  <= '0;
      angle_reg  <= '0;
      idx_reg    <= '0;
      start_reg  <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mode_reg   <= mode_next;
      fstart_reg <= fstart_next;
      fstop_reg  <= fstop_next;
      fstep_reg  <= fstep_next;
      angle_reg  <= angle_next;
      idx_reg    <= idx_next;
      start_reg  <= start_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  // Next-state and output logic; abort overrides everything at the end.
  always_comb begin
    state_next  = state_reg;
    mode_next   = mode_reg;
    fstart_next = fstart_reg;
    fstop_next  = fstop_reg;
    fstep_next  = fstep_reg;
    angle_next  = angle_reg;
    idx_next    = idx_reg;
    start_next  = start_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
    dwell_load  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        start_next = 1'b1;
        busy_next  = 1'b0;
        if (Go_i) begin
          if (FreqStart_i > FreqStop_i) begin
            err_next = 1'b1;
          end else begin
            dwell_load  = 1'b1;
            mode_next   = norm_mode(Mode_i);
            fstart_next = FreqStart_i;
            fstop_next  = FreqStop_i;
            fstep_next  = FreqStep_i;
            state_next  = ST_UP;
            angle_next  = FreqStart_i;
            idx_next    = '0;
            start_next  = 1'b0;
            busy_next   = 1'b1;
          end
        end
      end

      ST_UP: begin
        if (dwell_expire) begin
          if (up_ok) begin
            angle_next = up_next[W-1:0];
            idx_next   = idx_reg + IDX_W'(1);
          end else begin
            case (mode_reg)
              MODE_SAW: begin
                angle_next = fstart_reg;
                idx_next   = idx_reg + IDX_W'(1);
              end
              MODE_TRI: begin
                if (dn_ok) begin
                  state_next = ST_DOWN;
                  angle_next = dn_next[W-1:0];
                end
                idx_next = idx_reg + IDX_W'(1);
              end
              default: begin
                state_next = ST_IDLE;
                start_next = 1'b1;
                busy_next  = 1'b0;
                done_next  = 1'b1;
              end
            endcase
          end
        end
      end

      ST_DOWN: begin
        if (dwell_expire) begin
          if (dn_ok) begin
            angle_next = dn_next[W-1:0];
          end else begin
            state_next = ST_UP;
            angle_next = up_next[W-1:0];
          end
          idx_next = idx_reg + IDX_W'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
        start_next = 1'b1;
        busy_next  = 1'b0;
      end
    endcase

    if (Abort_i) begin
      state_next  = ST_IDLE;
      mode_next   = mode_reg;
      fstart_next = fstart_reg;
      fstop_next  = fstop_reg;
      fstep_next  = fstep_reg;
      angle_next  = angle_reg;
      idx_next    = idx_reg;
      start_next  = 1'b1;
      busy_next   = 1'b0;
      done_next   = 1'b0;
      err_next    = 1'b0;
      dwell_load  = 1'b0;
    end
  end

  assign Angle_o   = angle_reg;
  assign Start_o   = start_reg;
  assign Busy_o    = busy_reg;
  assign Done_o    = done_reg;
  assign Err_o     = err_reg;
  assign StepIdx_o = idx_reg;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for the NCO sweep controller with hand-computed sequences.
module tb_nco_sweep_ctrl;

  localparam int W       = 16;
  localparam int DWELL_W = 16;
  localparam int IDX_W   = 16;

  logic               clk;
  logic               rst;
  logic               go;
  logic               abort;
  logic [1:0]         mode;
  logic [W-1:0]       fstart;
  logic [W-1:0]       fstop;
  logic [W-1:0]       fstep;
  logic [DWELL_W-1:0] dwell;
  logic [W-1:0]       angle;
  logic               start_n;
  logic               busy;
  logic               done;
  logic               err;
  logic [IDX_W-1:0]   idx;

  int errors = 0;
  int checks = 0;

  nco_sweep_ctrl #(
    .W       (W),
    .DWELL_W (DWELL_W),
    .IDX_W   (IDX_W)
  ) dut (
    .Clk_i       (clk),
    .Rst_i       (rst),
    .Go_i        (go),
    .Abort_i     (abort),
    .Mode_i      (mode),
    .FreqStart_i (fstart),
    .FreqStop_i  (fstop),
    .FreqStep_i  (fstep),
    .Dwell_i     (dwell),
    .Angle_o     (angle),
    .Start_o     (start_n),
    .Busy_o      (busy),
    .Done_o      (done),
    .Err_o       (err),
    .StepIdx_o   (idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive Go for one cycle (cycle n), then scramble the inputs to prove they
  // were latched. Returns positioned at the sampling point of cycle n+1.
  task automatic pulse_go(input logic [1:0] m, input logic [W-1:0] s, input logic [W-1:0] e,
                          input logic [W-1:0] st, input logic [DWELL_W-1:0] d, input logic ab);
    @(negedge clk);
    go = 1'b1; abort = ab; mode = m; fstart = s; fstop = e; fstep = st; dwell = d;
    @(negedge clk);
    go = 1'b0; abort = 1'b0;
    mode = ~m; fstart = 16'h1234; fstop = 16'h0010; fstep = 16'h0777; dwell = 16'd9;
  endtask

  task automatic do_abort;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  int exp_angle;

  initial begin
    rst = 1'b1; go = 1'b0; abort = 1'b0; mode = 2'b00;
    fstart = '0; fstop = '0; fstep = '0; dwell = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("txn reset");
    check("rst_angle", angle, 0);
    check("rst_start", start_n, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_idx", idx, 0);

    // Single up 100..400 step 100 dwell 3.
    $display("txn single_up");
    pulse_go(2'b00, 16'd100, 16'd400, 16'd100, 16'd3, 1'b0);
    check("s1_start", start_n, 0);
    check("s1_busy", busy, 1);
    check("s1_idx0", idx, 0);
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      exp_angle = 100 * ((k - 1) / 3 + 1);
      check($sformatf("s1_angle_n%0d", k), angle, exp_angle);
      check($sformatf("s1_done_n%0d", k), done, 0);
    end
    @(negedge clk);
    check("s1_end_start", start_n, 1);
    check("s1_end_busy", busy, 0);
    check("s1_end_done", done, 1);
    check("s1_end_idx", idx, 3);
    check("s1_end_angle", angle, 400);
    @(negedge clk);
    check("s1_done_pulse", done, 0);

    // Non-multiple bound: last point 300, Done at n+10.
    $display("txn single_nonmultiple");
    pulse_go(2'b00, 16'd100, 16'd350, 16'd100, 16'd3, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) @(negedge clk);
      exp_angle = 100 * ((k - 1) / 3 + 1);
      check($sformatf("s2_angle_n%0d", k), angle, exp_angle);
    end
    @(negedge clk);
    check("s2_done", done, 1);
    check("s2_angle", angle, 300);
    check("s2_idx", idx, 2);

    // Sawtooth 0..200 step 100 dwell 1, abort at n+7.
    $display("txn sawtooth");
    pulse_go(2'b01, 16'd0, 16'd200, 16'd100, 16'd1, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) @(negedge clk);
      exp_angle = 100 * ((k - 1) % 3);
      check($sformatf("saw_angle_n%0d", k), angle, exp_angle);
      check($sformatf("saw_done_n%0d", k), done, 0);
    end
    check("saw_idx_n7", idx, 6);
    do_abort();
    check("saw_abort_start", start_n, 1);
    check("saw_abort_busy", busy, 0);
    check("saw_abort_done", done, 0);
    check("saw_abort_angle", angle, 0);

    // Triangle 0..300 step 100 dwell 1.
    $display("txn triangle");
    pulse_go(2'b10, 16'd0, 16'd300, 16'd100, 16'd1, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) @(negedge clk);
      case (k)
        1, 7:    exp_angle = 0;
        2, 6, 8: exp_angle = 100;
        3, 5, 9: exp_angle = 200;
        default: exp_angle = 300;
      endcase
      check($sformatf("tri_angle_n%0d", k), angle, exp_angle);
    end
    check("tri_idx_n9", idx, 8);
    do_abort();
    check("tri_abort_busy", busy, 0);

    // Overflow edge: one point FFF0 then Done, no wrap.
    $display("txn overflow");
    pulse_go(2'b00, 16'hFFF0, 16'hFFFF, 16'h0020, 16'd1, 1'b0);
    check("ovf_angle_n1", angle, 16'hFFF0);
    @(negedge clk);
    check("ovf_done", done, 1);
    check("ovf_angle_n2", angle, 16'hFFF0);
    check("ovf_start", start_n, 1);

    // Rejected Go: Start > Stop.
    $display("txn reject");
    pulse_go(2'b00, 16'd500, 16'd100, 16'd10, 16'd1, 1'b0);
    check("rej_err", err, 1);
    check("rej_start", start_n, 1);
    check("rej_busy", busy, 0);
    @(negedge clk);
    check("rej_err_pulse", err, 0);

    // Go and Abort together: nothing happens.
    $display("txn go_abort");
    pulse_go(2'b00, 16'd10, 16'd30, 16'd10, 16'd1, 1'b1);
    check("ga_busy", busy, 0);
    check("ga_err", err, 0);
    check("ga_start", start_n, 1);
    check("ga_angle", angle, 16'hFFF0);

    // Dwell 0 behaves as 1.
    $display("txn dwell_zero");
    pulse_go(2'b00, 16'd10, 16'd30, 16'd10, 16'd0, 1'b0);
    check("d0_angle_n1", angle, 10);
    @(negedge clk);
    check("d0_angle_n2", angle, 20);
    @(negedge clk);
    check("d0_angle_n3", angle, 30);
    @(negedge clk);
    check("d0_done", done, 1);

    // Zero step sawtooth holds Start forever.
    $display("txn saw_step0");
    pulse_go(2'b01, 16'd50, 16'd100, 16'd0, 16'd1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      check($sformatf("z_angle_n%0d", k), angle, 50);
      check($sformatf("z_busy_n%0d", k), busy, 1);
    end

    // Reset mid-sweep.
    $display("txn reset_mid");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rm_angle", angle, 0);
    check("rm_start", start_n, 1);
    check("rm_busy", busy, 0);
    check("rm_done", done, 0);
    check("rm_err", err, 0);
    check("rm_idx", idx, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
